wb_write_queue: RTL and testbench

//  Writer-side companion of the register file: collects writeback requests from the ALU and memory paths,

---
 rtl/wb_write_queue_pkg.sv | 14 +
 rtl/wb_write_queue_if.sv | 28 ++
 rtl/wb_write_queue_fifo.sv | 81 ++++++++
 rtl/wb_write_queue.sv | 123 ++++++++++++
 tb/tb_wb_write_queue.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_write_queue_pkg.sv
// Shared widths and source encoding for the writeback queue.
package wb_write_queue_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int REG_ADDR_W = 2;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MEM  = 2'd2
    } wb_src_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// Writeback request handshakes from the ALU and load-return paths.
interface wb_write_queue_if #(
    parameter int ADDR_W = wb_write_queue_pkg::REG_ADDR_W,
    parameter int WORD_W = wb_write_queue_pkg::WORD_SIZE
) ();

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [WORD_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [WORD_W-1:0] mem_data;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready
    );

endinterface

// File: rtl/wb_write_queue_fifo.sv
// Circular buffer of {reg,data} writes with an oldest-first view of all entries.
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int WORD_W = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic [ADDR_W-1:0]                push_reg,
    input  logic [WORD_W-1:0]                push_data,
    input  logic                             pop,
    output logic [ADDR_W-1:0]                head_reg,
    output logic [WORD_W-1:0]                head_data,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic [DEPTH-1:0]                 age_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]     age_reg,
    output logic [DEPTH-1:0][WORD_W-1:0]     age_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [DEPTH-1:0]  vld;
    logic [ADDR_W-1:0] ent_reg  [DEPTH];
    logic [WORD_W-1:0] ent_data [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (do_push) begin
                vld[tail] <= 1'b1;
                tail      <= tail + PW'(1);
            end
            if (do_pop) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Payload needs no reset: the valid mask guards every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ent_reg[tail]  <= push_reg;
            ent_data[tail] <= push_data;
        end
    end

    assign head_reg  = ent_reg[head];
    assign head_data = ent_data[head];

    always_comb begin
        age_valid = '0;
        age_reg   = '0;
        age_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            age_valid[k] = vld[head + PW'(k)];
            age_reg[k]   = ent_reg[head + PW'(k)];
            age_data[k]  = ent_data[head + PW'(k)];
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the register file's single write port,
// with per-register pending bits and youngest-value bypass.
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int WORD_W = WORD_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    wb_write_queue_if.slave              req,
    input  logic                         wb_hold,
    output logic                         rf_reg_write,
    output logic [ADDR_W-1:0]            rf_write_reg,
    output logic [WORD_W-1:0]            rf_write_data,
    output logic [(1<<ADDR_W)-1:0]       pending,
    input  logic [ADDR_W-1:0]            bypass_reg,
    output logic                         bypass_hit,
    output logic [WORD_W-1:0]            bypass_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    wb_src_t                         src;
    logic                            full;
    logic                            push;
    logic                            pop;
    logic [ADDR_W-1:0]               push_reg;
    logic [WORD_W-1:0]               push_data;
    logic [ADDR_W-1:0]               head_reg;
    logic [WORD_W-1:0]               head_data;
    logic [DEPTH-1:0]                age_valid;
    logic [DEPTH-1:0][ADDR_W-1:0]    age_reg;
    logic [DEPTH-1:0][WORD_W-1:0]    age_data;

    assign full          = (count == FULL);
    assign req.mem_ready = !full;
    assign req.alu_ready = !full && !req.mem_valid;
    assign pop           = (count != '0) && !wb_hold;

    // Load returns win; the ALU only sees ready when no load is offered.
    always_comb begin
        src       = SRC_NONE;
        push_reg  = '0;
        push_data = '0;
        unique case (1'b1)
            req.mem_valid && req.mem_ready: begin
                src       = SRC_MEM;
                push_reg  = req.mem_reg;
                push_data = req.mem_data;
            end
            req.alu_valid && req.alu_ready: begin
                src       = SRC_ALU;
                push_reg  = req.alu_reg;
                push_data = req.alu_data;
            end
            default: ;
        endcase
    end

    assign push = (src != SRC_NONE);

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_reg  (push_reg),
        .push_data (push_data),
        .pop       (pop),
        .head_reg  (head_reg),
        .head_data (head_data),
        .count     (count),
        .age_valid (age_valid),
        .age_reg   (age_reg),
        .age_data  (age_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_reg_write  <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else begin
            rf_reg_write <= pop;
            if (pop) begin
                rf_write_reg  <= head_reg;
                rf_write_data <= head_data;
            end
        end
    end

    always_comb begin
        pending = '0;
        if (rf_reg_write) pending[rf_write_reg] = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k]) pending[age_reg[k]] = 1'b1;
        end
    end

    // Output stage is oldest; scan queue oldest-first so the youngest match wins.
    always_comb begin
        bypass_hit  = 1'b0;
        bypass_data = '0;
        if (rf_reg_write && (rf_write_reg == bypass_reg)) begin
            bypass_hit  = 1'b1;
            bypass_data = rf_write_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (age_valid[k] && (age_reg[k] == bypass_reg)) begin
                bypass_hit  = 1'b1;
                bypass_data = age_data[k];
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed vector table plus hand sequences for full, bypass and reset cases.
module tb_wb_write_queue;

    logic        clk;
    logic        reset;
    logic        wb_hold;
    logic [1:0]  bypass_reg;
    logic        rf_reg_write;
    logic [1:0]  rf_write_reg;
    logic [15:0] rf_write_data;
    logic [3:0]  pending;
    logic        bypass_hit;
    logic [15:0] bypass_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    wb_write_queue_if #(.ADDR_W(2), .WORD_W(16)) wbif ();

    wb_write_queue #(.DEPTH(4), .ADDR_W(2), .WORD_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (wbif),
        .wb_hold       (wb_hold),
        .rf_reg_write  (rf_reg_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .pending       (pending),
        .bypass_reg    (bypass_reg),
        .bypass_hit    (bypass_hit),
        .bypass_data   (bypass_data),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        hold;
        logic        av;
        logic [1:0]  areg;
        logic [15:0] ad;
        logic        mv;
        logic [1:0]  mreg;
        logic [15:0] md;
        logic [1:0]  byp;
        logic        chk;
        logic [44:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [44:0] ex(
        input logic ar, mr, rw, input logic [1:0] wr, input logic [15:0] wd,
        input logic [3:0] pend, input logic hit, input logic [15:0] bd,
        input logic [2:0] cnt);
        return {ar, mr, rw, wr, wd, pend, hit, bd, cnt};
    endfunction

    function automatic vec_t mk(
        input logic rst, hold, av, input logic [1:0] areg,
        input logic [15:0] ad, input logic mv, input logic [1:0] mreg,
        input logic [15:0] md, input logic [1:0] byp, input logic chk,
        input logic [44:0] e);
        vec_t v;
        v.rst = rst; v.hold = hold; v.av = av; v.areg = areg; v.ad = ad;
        v.mv = mv; v.mreg = mreg; v.md = md; v.byp = byp; v.chk = chk;
        v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic idle_req();
        wbif.alu_valid = 1'b0; wbif.alu_reg = '0; wbif.alu_data = '0;
        wbif.mem_valid = 1'b0; wbif.mem_reg = '0; wbif.mem_data = '0;
    endtask

    logic [44:0] act;

    initial begin
        reset = 1'b1; wb_hold = 1'b0; bypass_reg = '0;
        idle_req();

        // reset, single ALU write, then mem-vs-alu collision
        vecs.push_back(mk(1,0,0,0,16'h0,0,0,16'h0,0,0, ex(0,0,0,0,0,0,0,0,0)));
        vecs.push_back(mk(1,0,0,0,16'h0,0,0,16'h0,0,1, ex(1,1,0,0,0,0,0,0,0)));
        vecs.push_back(mk(0,0,1,2,16'h1234,0,0,16'h0,2,1, ex(1,1,0,0,0,0,0,0,0)));
        vecs.push_back(mk(0,0,0,0,16'h0,0,0,16'h0,2,1,
                          ex(1,1,0,0,0,4'b0100,1,16'h1234,1)));
        vecs.push_back(mk(0,0,0,0,16'h0,0,0,16'h0,2,1,
                          ex(1,1,1,2,16'h1234,4'b0100,1,16'h1234,0)));
        vecs.push_back(mk(0,0,0,0,16'h0,0,0,16'h0,2,1,
                          ex(1,1,0,2,16'h1234,0,0,0,0)));
        vecs.push_back(mk(0,0,1,1,16'h0001,1,3,16'hBEEF,3,1,
                          ex(0,1,0,2,16'h1234,0,0,0,0)));
        vecs.push_back(mk(0,0,1,1,16'h0001,0,0,16'h0,3,1,
                          ex(1,1,0,2,16'h1234,4'b1000,1,16'hBEEF,1)));
        vecs.push_back(mk(0,0,0,0,16'h0,0,0,16'h0,3,1,
                          ex(1,1,1,3,16'hBEEF,4'b1010,1,16'hBEEF,1)));
        vecs.push_back(mk(0,0,0,0,16'h0,0,0,16'h0,1,1,
                          ex(1,1,1,1,16'h0001,4'b0010,1,16'h0001,0)));
        vecs.push_back(mk(0,0,0,0,16'h0,0,0,16'h0,1,1,
                          ex(1,1,0,1,16'h0001,0,0,0,0)));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; wb_hold = vecs[i].hold;
            wbif.alu_valid = vecs[i].av; wbif.alu_reg = vecs[i].areg;
            wbif.alu_data = vecs[i].ad; wbif.mem_valid = vecs[i].mv;
            wbif.mem_reg = vecs[i].mreg; wbif.mem_data = vecs[i].md;
            bypass_reg = vecs[i].byp;
            #1;
            if (vecs[i].chk) begin
                act = {wbif.alu_ready, wbif.mem_ready, rf_reg_write,
                       rf_write_reg, rf_write_data, pending, bypass_hit,
                       bypass_data, count};
                checks++;
                if (act !== vecs[i].exp) begin
                    errors++;
                    $display("FAIL vec%0d: got %h, expected %h",
                             i, act, vecs[i].exp);
                end
            end
        end

        // fill under hold, refuse a fifth, drain in order
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_req();
            wb_hold = 1'b1;
            wbif.alu_valid = 1'b1;
            wbif.alu_reg = 2'(i);
            wbif.alu_data = 16'hA000 + 16'(i);
        end
        @(negedge clk);
        wbif.alu_reg = 2'd0; wbif.alu_data = 16'hFFFF;
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_alu_ready", 32'(wbif.alu_ready), 32'd0);
        chk("full_mem_ready", 32'(wbif.mem_ready), 32'd0);
        chk("full_pending", 32'(pending), 32'hF);
        @(negedge clk);
        idle_req();
        wb_hold = 1'b0;
        #1;
        chk("fifth_refused", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("drain_we", 32'(rf_reg_write), 32'd1);
            chk("drain_reg", 32'(rf_write_reg), 32'(i));
            chk("drain_data", 32'(rf_write_data), 32'hA000 + 32'(i));
            chk("drain_count", 32'(count), 32'(3 - i));
        end
        @(negedge clk);
        #1;
        chk("drain_done", 32'(rf_reg_write), 32'd0);

        // same register queued twice: bypass takes the younger value
        @(negedge clk);
        wb_hold = 1'b1;
        wbif.alu_valid = 1'b1; wbif.alu_reg = 2'd0; wbif.alu_data = 16'h0011;
        @(negedge clk);
        wbif.alu_data = 16'h0022;
        @(negedge clk);
        idle_req();
        bypass_reg = 2'd0;
        #1;
        chk("dup_count", 32'(count), 32'd2);
        chk("dup_pending", 32'(pending), 32'h1);
        chk("dup_hit", 32'(bypass_hit), 32'd1);
        chk("dup_data", 32'(bypass_data), 32'h0022);
        bypass_reg = 2'd1;
        #1;
        chk("miss_hit", 32'(bypass_hit), 32'd0);
        chk("miss_data", 32'(bypass_data), 32'd0);
        wb_hold = 1'b0;
        @(negedge clk);
        #1;
        chk("dup_first", {15'd0, rf_reg_write, rf_write_data}, {15'd0, 1'b1, 16'h0011});
        @(negedge clk);
        #1;
        chk("dup_second", {15'd0, rf_reg_write, rf_write_data}, {15'd0, 1'b1, 16'h0022});
        @(negedge clk);
        #1;
        chk("dup_done", 32'(rf_reg_write), 32'd0);

        // reset mid-operation discards queued writes
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            wb_hold = 1'b1;
            wbif.alu_valid = 1'b1;
            wbif.alu_reg = 2'(i);
            wbif.alu_data = 16'h5000 + 16'(i);
        end
        @(negedge clk);
        idle_req();
        #1;
        chk("pre_reset_count", 32'(count), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wb_hold = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_readys", {30'd0, wbif.alu_ready, wbif.mem_ready}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("rst_no_write", {15'd0, rf_reg_write, rf_write_data}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
